// File: rtl/writeback_unit.sv
// Writeback stage: in-order result FIFO draining up to two entries per cycle.
// Optional WB_PENDING_EN adds a per-register outstanding-write mask.
module writeback_unit #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [1:0]        write_en,
   output logic [ADDR_W-1:0] reg_write_addr_0,
   output logic [ADDR_W-1:0] reg_write_addr_1,
   output logic [DATA_W-1:0] data_in_0,
   output logic [DATA_W-1:0] data_in_1
`ifdef WB_PENDING_EN
   ,
   output logic [7:0]        pending
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] LIM_A = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LIM_M = CW'(DEPTH - 2);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t          fifo_q [DEPTH];
   ent_t          fifo_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    we_q, we_d;
   ent_t          p0_q, p0_d, p1_q, p1_d;
   ent_t          h0, h1;
   logic          alu_push, mem_push;
   logic [1:0]    n_pop;

   // Ready uses only the registered count; same-cycle drains earn no credit.
   assign alu_ready = (cnt_q <= LIM_A);
   assign mem_ready = (cnt_q <= LIM_M);

   always_comb begin
      fifo_d   = fifo_q;
      p0_d     = p0_q;
      p1_d     = p1_q;
      we_d     = 2'b00;
      alu_push = alu_valid && alu_ready;
      mem_push = mem_valid && mem_ready;
      n_pop    = (cnt_q >= CW'(2)) ? 2'd2 : cnt_q[1:0];
      h0       = fifo_q[rd_q];
      h1       = fifo_q[rd_q + PW'(1)];
      unique case (n_pop)
         2'd1: begin
            we_d = 2'b01;
            p0_d = h0;
         end
         2'd2: begin
            p0_d = h0;
            p1_d = h1;
            we_d = (h0.addr == h1.addr) ? 2'b10 : 2'b11;
         end
         default: we_d = 2'b00;
      endcase
      rd_d = rd_q + PW'(n_pop);
      wr1  = wr_q + PW'(alu_push);
      if (alu_push) fifo_d[wr_q] = '{addr: alu_addr, data: alu_data};
      if (mem_push) fifo_d[wr1]  = '{addr: mem_addr, data: mem_data};
      wr_d  = wr1 + PW'(mem_push);
      cnt_d = cnt_q + CW'(alu_push) + CW'(mem_push) - CW'(n_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         we_q  <= 2'b00;
         p0_q  <= '0;
         p1_q  <= '0;
      end else begin
         fifo_q <= fifo_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         we_q   <= we_d;
         p0_q   <= p0_d;
         p1_q   <= p1_d;
      end
   end

   assign write_en         = we_q;
   assign reg_write_addr_0 = p0_q.addr;
   assign reg_write_addr_1 = p1_q.addr;
   assign data_in_0        = p0_q.data;
   assign data_in_1        = p1_q.data;

`ifdef WB_PENDING_EN
   logic [7:0]    pend;
   logic [PW-1:0] off;

   always_comb begin
      pend = '0;
      off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_q;
         if (CW'(off) < cnt_q) pend[fifo_q[i].addr] = 1'b1;
      end
      if (we_q[0]) pend[p0_q.addr] = 1'b1;
      if (we_q[1]) pend[p1_q.addr] = 1'b1;
   end

   assign pending = pend;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: vector table, scoreboard monitor,
// backpressure/random streams and a mid-run reset.
module tb_writeback_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [2:0]  alu_addr, mem_addr;
   logic [15:0] alu_data, mem_data;
   logic [1:0]  write_en;
   logic [2:0]  reg_write_addr_0, reg_write_addr_1;
   logic [15:0] data_in_0, data_in_1;
`ifdef WB_PENDING_EN
   logic [7:0]  pending;
`endif

   writeback_unit #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .write_en(write_en),
      .reg_write_addr_0(reg_write_addr_0),
      .reg_write_addr_1(reg_write_addr_1),
      .data_in_0(data_in_0), .data_in_1(data_in_1)
`ifdef WB_PENDING_EN
      , .pending(pending)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } ent_t;

   typedef struct {
      bit          av;
      logic [2:0]  aa;
      logic [15:0] ad;
      bit          mv;
      logic [2:0]  ma;
      logic [15:0] md;
      logic [1:0]  we;
      logic [2:0]  a0;
      logic [15:0] d0;
      logic [2:0]  a1;
      logic [15:0] d1;
   } vec_t;

   vec_t        tbl [6];
   ent_t        sb [$];
   int          vecs = 0;
   int          errs = 0;
   int          cnt_m = 0;
   bit          acc_a = 1'b0, acc_m = 1'b0;
   logic [15:0] rf [8];
   logic [15:0] ref_rf [8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   // Scoreboard monitor: outputs of the edge just past vs. in-order model.
   always @(negedge clk) begin
      int         n;
      logic [1:0] ew;
      logic [7:0] ep;
      ent_t       e0, e1;
      if (rst) begin
         sb.delete();
         cnt_m = 0;
         acc_a = 1'b0;
         acc_m = 1'b0;
      end else begin
         n  = (cnt_m < 2) ? cnt_m : 2;
         ew = 2'b00;
         ep = 8'h00;
         e0 = '0;
         e1 = '0;
         if (sb.size() < n) begin
            errs++;
            $display("FAIL sb_underflow: got %0d want %0d", sb.size(), n);
            n = sb.size();
         end
         if (n >= 1) e0 = sb.pop_front();
         if (n == 2) e1 = sb.pop_front();
         if (n == 1) ew = 2'b01;
         if (n == 2) ew = (e0.a == e1.a) ? 2'b10 : 2'b11;
         chk("mon_we", write_en, ew);
         if (n >= 1) begin
            chk("mon_a0", reg_write_addr_0, e0.a);
            chk("mon_d0", data_in_0, e0.d);
            ref_rf[e0.a] = e0.d;
            if (ew[0]) ep[e0.a] = 1'b1;
         end
         if (n == 2) begin
            chk("mon_a1", reg_write_addr_1, e1.a);
            chk("mon_d1", data_in_1, e1.d);
            ref_rf[e1.a] = e1.d;
            ep[e1.a] = 1'b1;
         end
         foreach (sb[i]) ep[sb[i].a] = 1'b1;
`ifdef WB_PENDING_EN
         chk("mon_pend", pending, ep);
`endif
         if (write_en[0]) rf[reg_write_addr_0] = data_in_0;
         if (write_en[1]) rf[reg_write_addr_1] = data_in_1;
         cnt_m = cnt_m + int'(acc_a) + int'(acc_m) - n;
         chk("mon_alu_rdy", alu_ready, cnt_m <= DEPTH - 1);
         chk("mon_mem_rdy", mem_ready, cnt_m <= DEPTH - 2);
         acc_a = alu_valid && (cnt_m <= DEPTH - 1);
         acc_m = mem_valid && (cnt_m <= DEPTH - 2);
         if (acc_a) sb.push_back(ent_t'{a: alu_addr, d: alu_data});
         if (acc_m) sb.push_back(ent_t'{a: mem_addr, d: mem_data});
      end
   end

   initial begin
      tbl[0] = '{1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0000,
                 2'b01, 3'd3, 16'hBEEF, 3'd0, 16'h0000};
      tbl[1] = '{1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222,
                 2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222};
      tbl[2] = '{1, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555,
                 2'b10, 3'd5, 16'hAAAA, 3'd5, 16'h5555};
      tbl[3] = '{0, 3'd0, 16'h0000, 1, 3'd7, 16'h7777,
                 2'b01, 3'd7, 16'h7777, 3'd5, 16'h5555};
      tbl[4] = '{1, 3'd0, 16'h0000, 1, 3'd0, 16'hFFFF,
                 2'b10, 3'd0, 16'h0000, 3'd0, 16'hFFFF};
      tbl[5] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000,
                 2'b00, 3'd0, 16'h0000, 3'd0, 16'hFFFF};
      for (int i = 0; i < 8; i++) begin
         rf[i]     = 16'h0000;
         ref_rf[i] = 16'h0000;
      end
      rst = 1'b1;
      idle();
      alu_addr = '0; alu_data = '0;
      mem_addr = '0; mem_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_we", write_en, 2'b00);
      chk("rst_a0", reg_write_addr_0, 3'd0);
      chk("rst_d0", data_in_0, 16'h0000);
      chk("rst_a1", reg_write_addr_1, 3'd0);
      chk("rst_d1", data_in_1, 16'h0000);
      chk("rst_alu_rdy", alu_ready, 1'b1);
      chk("rst_mem_rdy", mem_ready, 1'b1);
`ifdef WB_PENDING_EN
      chk("rst_pend", pending, 8'h00);
`endif
      @(posedge clk);
      #2 rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         step();
         alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
         mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
         step();
         idle();
         step();
         chk($sformatf("v%0d_we", i), write_en, tbl[i].we);
         chk($sformatf("v%0d_a0", i), reg_write_addr_0, tbl[i].a0);
         chk($sformatf("v%0d_d0", i), data_in_0, tbl[i].d0);
         chk($sformatf("v%0d_a1", i), reg_write_addr_1, tbl[i].a1);
         chk($sformatf("v%0d_d1", i), data_in_1, tbl[i].d1);
         step();
      end
      step();
      chk("rf3", rf[3], 16'hBEEF);
      chk("rf1", rf[1], 16'h1111);
      chk("rf2", rf[2], 16'h2222);
      chk("rf5", rf[5], 16'h5555);
      chk("rf7", rf[7], 16'h7777);
      chk("rf0", rf[0], 16'hFFFF);

`ifdef WB_PENDING_EN
      step();
      alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h6666;
      step();
      idle();
      chk("pend_acc", pending, 8'h40);
      step();
      chk("pend_out", pending, 8'h40);
      step();
      chk("pend_clr", pending, 8'h00);
`endif

      for (int k = 0; k < 40; k++) begin
         step();
         alu_valid = 1'b1; alu_addr = 3'(k);     alu_data = 16'(2 * k);
         mem_valid = 1'b1; mem_addr = 3'(k * 3); mem_data = 16'h8000 + 16'(k);
      end
      for (int k = 0; k < 60; k++) begin
         step();
         alu_valid = 1'($urandom_range(0, 1));
         mem_valid = 1'($urandom_range(0, 1));
         alu_addr  = 3'($urandom);
         mem_addr  = 3'($urandom);
         alu_data  = 16'($urandom);
         mem_data  = 16'($urandom);
      end
      step();
      rst = 1'b1;
      idle();
      #1;
      chk("mid_rst_we", write_en, 2'b00);
      chk("mid_rst_alu_rdy", alu_ready, 1'b1);
      chk("mid_rst_mem_rdy", mem_ready, 1'b1);
`ifdef WB_PENDING_EN
      chk("mid_rst_pend", pending, 8'h00);
`endif
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         alu_valid = 1'b1; alu_addr = 3'(k + 2); alu_data = 16'hC000 + 16'(k);
         mem_valid = 1'b1; mem_addr = 3'(k + 5); mem_data = 16'hD000 + 16'(k);
      end
      step();
      idle();
      repeat (5) step();
      chk("sb_empty", sb.size(), 0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rf_ref%0d", i), rf[i], ref_rf[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Writeback stage directly upstream of the 8x16 dual-write-port register file.
- Accepts results from the ALU and the memory/load path through valid/ready handshakes.
- Buffers accepted results in an in-order FIFO.
- Drains up to two results per cycle onto the register file write ports: write_en[1:0], reg_write_addr_0/1, data_in_0/1.
- Optionally exports a per-register pending mask for decode hazard checks.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
DATA_W, 16, result data width; matches register width.
ADDR_W, 3, destination register index width (8 registers).

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted when alu_valid && alu_ready at posedge
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result valid
mem_ready  output  1  load result accepted when mem_valid && mem_ready at posedge
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load result
write_en  output  2  bit0 enables write port 0, bit1 enables write port 1
reg_write_addr_0  output  ADDR_W  write port 0 register select
reg_write_addr_1  output  ADDR_W  write port 1 register select
data_in_0  output  DATA_W  write port 0 data
data_in_1  output  DATA_W  write port 1 data
pending  output  8  per-register outstanding-write mask; present only with WB_PENDING_EN

Behaviour:
- Reset (async, rst high): FIFO emptied, count=0, write_en=2'b00, reg_write_addr_0/1=0, data_in_0/1=0, pending=0. Any in-flight results are discarded.
- Reset outputs hold for as long as rst is high. The first accept is possible at the first posedge after rst deasserts.
- Ready generation depends only on registered count, never on the valid inputs:
  - alu_ready = (DEPTH - count) >= 1
  - mem_ready = (DEPTH - count) >= 2
  - Entries drained in the same cycle are not credited. Ready is conservative and the FIFO can never overflow.
- Enqueue order within one cycle: the ALU entry is pushed first (older), then the memory entry (younger). With a single accept, that entry takes the next slot.
- Dequeue: each posedge pops n = min(count, 2) entries from the pre-edge FIFO head into the registered output stage. Pop and push happen in the same cycle.
- count_next = count + pushes - n. count is (clog2(DEPTH)+1) bits wide. Read and write pointers wrap modulo DEPTH.
- Output stage (registered):
  - n=0: write_en=00.
  - n=1: the entry goes to port 0, write_en=01.
  - n=2: the older entry goes to port 0 and the younger to port 1, write_en=11.
- Same-address collision: when n=2 and both entries target the same register, port 0 is suppressed (write_en=10). Only the younger value is written. Port 0 addr/data are still driven with the older entry.
- Outputs with write_en bit low hold their previous addr/data values.
- Latency: result accepted at edge E -> popped at edge E+1 (write_en asserted during the cycle after E+1) -> committed in the register file at edge E+2, when the FIFO held no older entries.
- Throughput: 2 results/cycle sustained.
- In-order guarantee: a later result to register R is never written before an earlier result to R.
- pending[r] = 1 iff any FIFO entry, or any output-stage entry with its write_en bit set, targets register r. Computed combinationally from registered state. It clears in the cycle after the register file commits the write.

Optional Feature:
- Macro: WB_PENDING_EN.
- Defined: the pending[7:0] port and its logic exist, with behaviour as above.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then single ALU result alu_addr=3, alu_data=16'hBEEF accepted at edge E -> write_en=01, reg_write_addr_0=3, data_in_0=BEEF during cycle after E+1. Register 3 reads BEEF after E+2.
- Same cycle: ALU (addr 1, 16'h1111) and mem (addr 2, 16'h2222) -> next-next cycle write_en=11, port0=(1,1111), port1=(2,2222).
- Same cycle: ALU (addr 5, 16'hAAAA) and mem (addr 5, 16'h5555) -> write_en=10, port1=(5,5555). Register 5 = 5555, never AAAA.
- DEPTH=4 backpressure:
  - Stimulus: both valids held high every cycle, data counting up.
  - Required: mem_ready low whenever count>=3 and alu_ready low whenever count=4; no accepted result lost or duplicated.
  - Required: register file contents match an in-order reference model.
- Reset mid-operation: rst pulsed between edges with 3 entries queued -> write_en=00, alu_ready=mem_ready=1, pending=0 immediately. No writes from discarded entries.
- WB_PENDING_EN: accept alu_addr=6 -> pending=8'h40 from the cycle after acceptance through the commit cycle, then 8'h00.
